button_conditioner: RTL and testbench



---
 rtl/channel_strip_pkg.sv | 16 +
 rtl/button_debounce_ch.sv | 44 ++++
 rtl/button_conditioner.sv | 123 ++++++++++++
 tb/tb_button_conditioner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/channel_strip_pkg.sv
// Shared constants and types for the channel-strip button front end.
package channel_strip_pkg;

  localparam int NUM_BUTTONS   = 16;

  // Button group bases within the 16-bit button vector
  localparam int FREQ_BTN_BASE = 0;
  localparam int LP_BTN_BASE   = 8;
  localparam int HP_BTN_BASE   = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } out_state_e;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, saturating debounce counter,
// debounced level register and registered press (rising-edge) event.
module button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic stable,
  output logic press_evt
);
  import channel_strip_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_prev_q;

  // The >= compare doubles as saturation: the counter can never pass CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      stable        <= 1'b0;
      stable_prev_q <= 1'b0;
      press_evt     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], button_raw};
      stable_prev_q <= stable;
      press_evt     <= stable & ~stable_prev_q;
      if (sync_q[1] == stable) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        stable <= ~stable;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BUTTONS raw buttons and issues one-hot press pulses in index order.
// Define BTN_PULSE_STRETCH_EN to stretch pulses to STRETCH_CYCLES with a gap cycle.
module button_conditioner #(
  parameter int NUM_BUTTONS     = channel_strip_pkg::NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STRETCH_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_pulse,
  output logic                   pulse_valid,
  output logic [NUM_BUTTONS-1:0] buttons_stable,
  output logic                   drop_flag
);
  import channel_strip_pkg::*;

  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] press_evt;
  logic [NUM_BUTTONS-1:0] pending_q;
  logic [NUM_BUTTONS-1:0] pending_next;
  logic [NUM_BUTTONS-1:0] req;
  logic [NUM_BUTTONS-1:0] grant;
  logic [NUM_BUTTONS-1:0] pulse_q;
  logic [NUM_BUTTONS-1:0] pulse_next;
  logic                   drop_q;
  logic                   load_ok;
  logic                   pulse_done;
  out_state_e             state_q;
  out_state_e             state_next;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .button_raw(buttons_raw[i]),
      .stable    (stable[i]),
      .press_evt (press_evt[i])
    );
  end

`ifdef BTN_PULSE_STRETCH_EN
  localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  logic [STR_W-1:0] stretch_q;
  logic [STR_W-1:0] stretch_next;

  assign pulse_done = (stretch_q == STR_W'(STRETCH_CYCLES - 1));

  always_comb begin
    stretch_next = '0;
    if (state_q == PULSE && !pulse_done) begin
      stretch_next = stretch_q + STR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_next;
    end
  end
`else
  assign pulse_done = 1'b1;
`endif

  // Arbitration only happens when the output can accept a new grant; the
  // lowest set request bit wins (two's-complement isolate-lowest-one trick).
  always_comb begin
    state_next = state_q;
    pulse_next = pulse_q;
    grant      = '0;
    load_ok    = 1'b0;
    req        = pending_q | press_evt;

    case (state_q)
      IDLE: begin
        load_ok = 1'b1;
      end
      PULSE: begin
`ifdef BTN_PULSE_STRETCH_EN
        if (pulse_done) begin
          pulse_next = '0;
          state_next = IDLE;
        end
`else
        load_ok = pulse_done;
`endif
      end
    endcase

    if (load_ok) begin
      grant      = req & (~req + NUM_BUTTONS'(1));
      pulse_next = grant;
      state_next = (|grant) ? PULSE : IDLE;
    end

    pending_next = req & ~grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pulse_q   <= '0;
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_next;
      pulse_q   <= pulse_next;
      pending_q <= pending_next;
      drop_q    <= drop_q | (|(press_evt & pending_q));
    end
  end

  assign buttons_pulse  = pulse_q;
  assign pulse_valid    = |pulse_q;
  assign buttons_stable = stable;
  assign drop_flag      = drop_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (default build, DEBOUNCE_CYCLES=4).
module tb_button_conditioner;

  logic        clk;
  logic        reset;
  logic [15:0] buttons_raw;
  logic [15:0] buttons_pulse;
  logic        pulse_valid;
  logic [15:0] buttons_stable;
  logic        drop_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] raw;
    int          len;
    logic [15:0] exp_pulse;
    logic [15:0] exp_stable;
    logic        exp_drop;
  } vec_t;

  vec_t clean_vecs[6];

  button_conditioner #(
    .NUM_BUTTONS    (16),
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .buttons_pulse (buttons_pulse),
    .pulse_valid   (pulse_valid),
    .buttons_stable(buttons_stable),
    .drop_flag     (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 ns after the next rising edge
  task automatic applyStimulus(input logic [15:0] raw, input logic rst);
    @(negedge clk);
    buttons_raw = raw;
    reset       = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic compareVal(input string name, input string field,
                            input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp_pulse,
                             input logic [15:0] exp_stable, input logic exp_drop);
    compareVal(name, "pulse", buttons_pulse, exp_pulse);
    compareVal(name, "valid", {15'b0, pulse_valid}, {15'b0, (exp_pulse != 16'h0)});
    compareVal(name, "stable", buttons_stable, exp_stable);
    compareVal(name, "drop", {15'b0, drop_flag}, {15'b0, exp_drop});
  endtask

  task automatic doReset(input string name);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(16'h0000, 1'b1);
      checkOutput(name, 16'h0000, 16'h0000, 1'b0);
    end
  endtask

  initial begin
    buttons_raw = 16'h0000;
    reset       = 1'b1;

    clean_vecs[0] = '{16'h0020,  5, 16'h0000, 16'h0000, 1'b0};
    clean_vecs[1] = '{16'h0020,  2, 16'h0000, 16'h0020, 1'b0};
    clean_vecs[2] = '{16'h0020,  1, 16'h0020, 16'h0020, 1'b0};
    clean_vecs[3] = '{16'h0020, 12, 16'h0000, 16'h0020, 1'b0};
    clean_vecs[4] = '{16'h0000,  5, 16'h0000, 16'h0020, 1'b0};
    clean_vecs[5] = '{16'h0000, 10, 16'h0000, 16'h0000, 1'b0};

    $display("[TB] starting button_conditioner bench");
    doReset("reset_state");

    // Clean press of bit 5: pulse exactly once at step 7, nothing on release
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < clean_vecs[v].len; c++) begin
        applyStimulus(clean_vecs[v].raw, 1'b0);
        checkOutput($sformatf("clean_v%0d_c%0d", v, c), clean_vecs[v].exp_pulse,
                    clean_vecs[v].exp_stable, clean_vecs[v].exp_drop);
      end
    end

    // Bit 2 bouncing every 2 cycles never gets accepted
    doReset("reset_glitch");
    for (int c = 0; c < 40; c++) begin
      applyStimulus((c < 30 && ((c / 2) % 2 == 0)) ? 16'h0004 : 16'h0000, 1'b0);
      checkOutput($sformatf("glitch_c%0d", c), 16'h0000, 16'h0000, 1'b0);
    end

    // Bits 3, 9, 15 together: issued lowest first on consecutive cycles
    doReset("reset_multi");
    for (int k = 0; k < 16; k++) begin
      logic [15:0] ep;
      ep = (k == 7) ? 16'h0008 : (k == 8) ? 16'h0200 : (k == 9) ? 16'h8000 : 16'h0000;
      applyStimulus(16'h8208, 1'b0);
      checkOutput($sformatf("multi_k%0d", k), ep, (k >= 5) ? 16'h8208 : 16'h0000, 1'b0);
    end

    // All 16 pressed; bit 15 re-pressed while still queued sets drop_flag
    // and is still pulsed exactly once
    doReset("reset_drop");
    for (int k = 0; k < 36; k++) begin
      logic [15:0] ep;
      logic [15:0] es;
      ep = (k >= 7 && k <= 22) ? (16'h0001 << (k - 7)) : 16'h0000;
      es = (k < 5) ? 16'h0000 : (k >= 11 && k <= 16) ? 16'h7FFF : 16'hFFFF;
      applyStimulus((k >= 6 && k <= 11) ? 16'h7FFF : 16'hFFFF, 1'b0);
      checkOutput($sformatf("drop_k%0d", k), ep, es, (k >= 19));
    end

    // Reset clears the sticky drop_flag
    doReset("reset_clears_drop");

    // Reset one cycle into a debounce leaves nothing behind
    applyStimulus(16'h0010, 1'b0);
    checkOutput("rst_early_k0", 16'h0000, 16'h0000, 1'b0);
    applyStimulus(16'h0010, 1'b1);
    checkOutput("rst_early_k1", 16'h0000, 16'h0000, 1'b0);
    for (int k = 2; k < 16; k++) begin
      applyStimulus(16'h0000, 1'b0);
      checkOutput($sformatf("rst_early_k%0d", k), 16'h0000, 16'h0000, 1'b0);
    end

    // Reset during the pulse train of bits 0,1 with raw held: the queued
    // pulse is lost and only a fresh debounce produces new pulses
    doReset("reset_mid_pulse");
    for (int k = 0; k < 22; k++) begin
      logic [15:0] ep;
      logic [15:0] es;
      ep = (k == 7 || k == 16) ? 16'h0001 : (k == 17) ? 16'h0002 : 16'h0000;
      es = ((k >= 5 && k <= 7) || k >= 14) ? 16'h0003 : 16'h0000;
      applyStimulus(16'h0003, (k == 8));
      checkOutput($sformatf("rst_pulse_k%0d", k), ep, es, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
